// File: rtl/str2num_accum_datapath_if.sv
// Bundle of data and control signals between the str2num controller and its
// accumulating datapath.
interface str2num_accum_datapath_if;
  logic [31:0] digit;
  logic [31:0] coef;
  logic        Init;
  logic        Ld;
  logic [31:0] num;
  logic [31:0] Mult;
  logic [31:0] Add;

  modport master (
    output digit, coef, Init, Ld,
    input  num, Mult, Add
  );

  modport slave (
    input  digit, coef, Init, Ld,
    output num, Mult, Add
  );
endinterface

// File: rtl/str2num_accum_datapath.sv
// Accumulating datapath for str2num: num <= num*coef + digit (low 32 bits),
// built from a combinational multiplier, an adder and an initialisable register.

module multiplier_32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);
  logic [31:0] acc;

  // Shift-add array; only the partial products that land in the low 32 bits matter.
  always_comb begin
    acc = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) acc = acc + (a << i);
    end
    p = acc;
  end
endmodule

module adder_32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);
  assign s = a + b;
endmodule

module register_32b_init (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        ld,
  input  logic [31:0] d,
  output logic [31:0] q
);
  logic [31:0] val_q;
  logic [31:0] val_d;

  // Init wins over Ld; otherwise hold.
  always_comb begin
    val_d = val_q;
    if (init)    val_d = 32'd0;
    else if (ld) val_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) val_q <= 32'd0;
    else     val_q <= val_d;
  end

  assign q = val_q;
endmodule

module str2num_accum_datapath (
  input  logic                      Clk,
  input  logic                      Rst,
  str2num_accum_datapath_if.slave   dp
);
  logic [31:0] num_w;
  logic [31:0] mult_w;
  logic [31:0] add_w;

  multiplier_32b u_mult (
    .a (num_w),
    .b (dp.coef),
    .p (mult_w)
  );

  adder_32b u_add (
    .a (dp.digit),
    .b (mult_w),
    .s (add_w)
  );

  register_32b_init u_reg (
    .clk  (Clk),
    .rst  (Rst),
    .init (dp.Init),
    .ld   (dp.Ld),
    .d    (add_w),
    .q    (num_w)
  );

  assign dp.num  = num_w;
  assign dp.Mult = mult_w;
  assign dp.Add  = add_w;
endmodule

// File: tb/tb_str2num_accum_datapath.sv
// Scoreboard bench for str2num_accum_datapath: expected num values are queued
// as each step is driven and compared one edge later.
module tb_str2num_accum_datapath;
  logic Clk;
  logic Rst;
  int   checks;
  int   failures;
  logic [31:0] expQ[$];
  logic [31:0] modelNum;

  str2num_accum_datapath_if dp ();

  str2num_accum_datapath dut (
    .Clk (Clk),
    .Rst (Rst),
    .dp  (dp)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", tag, act, exp);
    end
  endtask

  // Drive one step at the falling edge, check the combinational outputs, then
  // compare num after the next rising edge against the queued expectation.
  task automatic applyStimulus(input string tag, input logic init, input logic ld,
                               input logic [31:0] coef, input logic [31:0] digit,
                               input logic [31:0] expNum);
    logic [31:0] got;
    @(negedge Clk);
    dp.Init  = init;
    dp.Ld    = ld;
    dp.coef  = coef;
    dp.digit = digit;
    expQ.push_back(expNum);
    #1;
    checkOutput({tag, "_mult"}, dp.Mult, modelNum * coef);
    checkOutput({tag, "_add"},  dp.Add,  modelNum * coef + digit);
    @(posedge Clk);
    #1;
    if (expQ.size() == 0) begin
      checkOutput({tag, "_queue"}, 32'd1, 32'd0);
    end else begin
      got = expQ.pop_front();
      checkOutput({tag, "_num"}, dp.num, got);
      modelNum = got;
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      dp.Init = 1'b0;
      dp.Ld   = 1'b0;
      dp.coef  = 32'd10;
      dp.digit = 32'd9;
      @(posedge Clk);
      #1;
      checkOutput("hold_num", dp.num, modelNum);
    end
  endtask

  task automatic pulseReset();
    @(negedge Clk);
    dp.Init = 1'b0;
    dp.Ld   = 1'b0;
    #2;
    Rst = 1'b1;
    #1;
    checkOutput("rst_async_num", dp.num, 32'd0);
    #1;
    Rst = 1'b0;
    modelNum = 32'd0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    modelNum = 32'd0;
    Rst      = 1'b1;
    dp.Init  = 1'b0;
    dp.Ld    = 1'b0;
    dp.coef  = 32'd0;
    dp.digit = 32'd3;
    #3;
    checkOutput("reset_num",  dp.num,  32'd0);
    checkOutput("reset_mult", dp.Mult, 32'd0);
    checkOutput("reset_add",  dp.Add,  32'd3);
    @(negedge Clk);
    Rst = 1'b0;
    idleCycles(3);

    // Decimal 561
    applyStimulus("dec_init", 1'b1, 1'b0, 32'd10, 32'd0, 32'd0);
    applyStimulus("dec_5",    1'b0, 1'b1, 32'd10, 32'd5, 32'd5);
    applyStimulus("dec_6",    1'b0, 1'b1, 32'd10, 32'd6, 32'd56);
    applyStimulus("dec_1",    1'b0, 1'b1, 32'd10, 32'd1, 32'h231);
    idleCycles(1);
    pulseReset();
    idleCycles(1);

    // Binary 110
    applyStimulus("bin_init", 1'b1, 1'b0, 32'd2, 32'd0, 32'd0);
    applyStimulus("bin_1a",   1'b0, 1'b1, 32'd2, 32'd1, 32'd1);
    applyStimulus("bin_1b",   1'b0, 1'b1, 32'd2, 32'd1, 32'd3);
    applyStimulus("bin_0",    1'b0, 1'b1, 32'd2, 32'd0, 32'd6);

    // Hex 1E, then decimal 0220
    applyStimulus("hex_init", 1'b1, 1'b0, 32'd16, 32'd0,  32'd0);
    applyStimulus("hex_1",    1'b0, 1'b1, 32'd16, 32'd1,  32'd1);
    applyStimulus("hex_e",    1'b0, 1'b1, 32'd16, 32'd14, 32'h1E);
    applyStimulus("d2_init",  1'b1, 1'b0, 32'd10, 32'd0,  32'd0);
    applyStimulus("d2_0a",    1'b0, 1'b1, 32'd10, 32'd0,  32'd0);
    applyStimulus("d2_2a",    1'b0, 1'b1, 32'd10, 32'd2,  32'd2);
    applyStimulus("d2_2b",    1'b0, 1'b1, 32'd10, 32'd2,  32'd22);
    applyStimulus("d2_0b",    1'b0, 1'b1, 32'd10, 32'd0,  32'd220);

    // Overflow wrap
    applyStimulus("ovf_load", 1'b0, 1'b1, 32'd0,       32'hFFFFFFFF, 32'hFFFFFFFF);
    applyStimulus("ovf_x2",   1'b0, 1'b1, 32'd2,       32'd1,        32'hFFFFFFFF);
    applyStimulus("ovf_x64k", 1'b0, 1'b1, 32'h10000,   32'd0,        32'hFFFF0000);

    // Init beats Ld
    applyStimulus("pri_init", 1'b1, 1'b0, 32'd10, 32'd0, 32'd0);
    applyStimulus("pri_5",    1'b0, 1'b1, 32'd10, 32'd5, 32'd5);
    applyStimulus("pri_6",    1'b0, 1'b1, 32'd10, 32'd6, 32'd56);
    applyStimulus("pri_1",    1'b0, 1'b1, 32'd10, 32'd1, 32'd561);
    applyStimulus("pri_both", 1'b1, 1'b1, 32'd10, 32'd4, 32'd0);

    // Reset between loads, continue from zero without Init
    applyStimulus("rl_5",     1'b0, 1'b1, 32'd10, 32'd5, 32'd5);
    applyStimulus("rl_6",     1'b0, 1'b1, 32'd10, 32'd6, 32'd56);
    pulseReset();
    applyStimulus("rl_7",     1'b0, 1'b1, 32'd10, 32'd7, 32'd7);
    idleCycles(2);

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
